div32_16: RTL and testbench

- Multi-cycle signed divider, the inverse of the 16x16 signed multiplier `mul16_16`: a 32-bit product divided by a 16-bit operand recovers the other 16-bit operand.
- Serial restoring algorithm, one quotient bit per clock.
- Valid/ready handshake on both the input and output sides.
- Sits downstream of `mul16_16` in the arithmetic datapath; also used standalone as the normalisation divider.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 20 ++
 rtl/div32_16.sv | 136 +++++++++++++
 tb/tb_div32_16.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared sizes, FSM encoding and constants for the serial signed divider.
package div_pkg;
  localparam int unsigned DW = 16;
  localparam int unsigned NW = 2 * DW;
  localparam int unsigned CW = 6;
  localparam logic [DW-1:0] DBZ_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step
  import div_pkg::*;
(
  input  logic [DW:0] rem_in,
  input  logic        bit_in,
  input  logic [DW:0] dsr,
  output logic [DW:0] rem_out,
  output logic        q_bit
);
  logic [DW+1:0] shifted;
  logic [DW+1:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, dsr};
    q_bit   = ~diff[DW+1];
    rem_out = q_bit ? diff[DW:0] : shifted[DW:0];
  end
endmodule

// File: rtl/div32_16.sv
// 32/16 signed serial restoring divider with valid/ready on both sides.
// Define DIV32_16_OVF_EN to add the ovf output and saturate overflowing quotients.
module div32_16
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          dbz
`ifdef DIV32_16_OVF_EN
  ,
  output logic          ovf
`endif
);
  state_t        state_q, state_nxt;
  logic [CW-1:0] cnt_q;
  // Dividend bits shift out of the top while quotient bits shift into the bottom.
  logic [NW-1:0] acc_q;
  logic [DW:0]   rem_q;
  logic [DW:0]   dsr_q;
  logic          neg_q_q, neg_r_q, dbz_q;
  logic [DW-1:0] dvd_lo_q;

  logic [NW-1:0] dvd_abs;
  logic [DW:0]   dsr_abs;
  logic [DW:0]   rem_nxt;
  logic          q_bit;
  logic [DW-1:0] quot_fix;
  logic [DW-1:0] rem_fix;
`ifdef DIV32_16_OVF_EN
  logic          ovf_fix;
`endif

  div_step u_step (
    .rem_in (rem_q),
    .bit_in (acc_q[NW-1]),
    .dsr    (dsr_q),
    .rem_out(rem_nxt),
    .q_bit  (q_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (cnt_q == CW'(NW - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand magnitudes and sign application of the final result
  always_comb begin
    dvd_abs  = dividend[NW-1] ? NW'(-dividend) : dividend;
    dsr_abs  = {1'b0, (divisor[DW-1] ? DW'(-divisor) : divisor)};
    quot_fix = neg_q_q ? DW'(-acc_q[DW-1:0]) : acc_q[DW-1:0];
    rem_fix  = neg_r_q ? DW'(-rem_q[DW-1:0]) : rem_q[DW-1:0];
`ifdef DIV32_16_OVF_EN
    ovf_fix = neg_q_q ? (acc_q > NW'(2 ** (DW - 1))) : (acc_q > NW'(2 ** (DW - 1) - 1));
    if (ovf_fix) quot_fix = neg_q_q ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    if (dbz_q) begin
      quot_fix = DBZ_QUOT;
      rem_fix  = dvd_lo_q;
`ifdef DIV32_16_OVF_EN
      ovf_fix  = 1'b0;
`endif
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
`ifdef DIV32_16_OVF_EN
      ovf       <= 1'b0;
`endif
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dbz_q     <= 1'b0;
      dvd_lo_q  <= '0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      case (state_q)
        IDLE: if (in_valid) begin
          acc_q    <= dvd_abs;
          rem_q    <= '0;
          dsr_q    <= dsr_abs;
          neg_q_q  <= dividend[NW-1] ^ divisor[DW-1];
          neg_r_q  <= dividend[NW-1];
          dbz_q    <= (divisor == '0);
          dvd_lo_q <= dividend[DW-1:0];
          cnt_q    <= '0;
        end
        CALC: begin
          acc_q <= {acc_q[NW-2:0], q_bit};
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          quotient  <= quot_fix;
          remainder <= rem_fix;
          dbz       <= dbz_q;
`ifdef DIV32_16_OVF_EN
          ovf       <= ovf_fix;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div32_16.sv
// Self-checking bench for div32_16 against a plain-arithmetic signed division model.
// Honours DIV32_16_OVF_EN to follow the saturating build.
module tb_div32_16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        dbz;
`ifdef DIV32_16_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div32_16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .dbz      (dbz)
`ifdef DIV32_16_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  // Reference: signed 64-bit division, truncating toward zero
  function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic z, output logic o);
    longint sa, sb, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      z = 1'b1; o = 1'b0; q = 16'hFFFF; r = a[15:0];
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      z  = 1'b0;
      o  = (qq > 32767) || (qq < -32768);
      q  = 16'(qq);
      r  = 16'(rr);
`ifdef DIV32_16_OVF_EN
      if (o) q = (qq > 0) ? 16'h7FFF : 16'h8000;
`endif
    end
  endfunction

  // Drive one operation, wait for the result, capture it and consume it
  task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic z, output logic o, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL timeout a=%h b=%h out_valid=%b required=1", a, b, out_valid);
    end
    q = quotient; r = remainder; z = dbz;
`ifdef DIV32_16_OVF_EN
    o = ovf;
`else
    o = 1'b0;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({in_ready, out_valid, quotient, remainder, dbz} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset in_ready=%b out_valid=%b q=%h r=%h dbz=%b required 1 0 0000 0000 0",
               in_ready, out_valid, quotient, remainder, dbz);
    end
`ifdef DIV32_16_OVF_EN
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b required=0", ovf); end
`endif
  endtask

  task automatic test_directed();
    logic [31:0] va [7];
    logic [15:0] vb [7];
    logic [15:0] eq [7];
    logic [15:0] er [7];
    logic        ez [7];
    logic        eo [7];
    logic [15:0] q, r, mq, mr;
    logic        z, o, mz, mo;
    int          lat;
    va = '{32'h3FFF0001, 32'hFFFD0000, 32'hFFFFFFF9, 32'h00000007, 32'h00001234, 32'h40000000, 32'h80000000};
    vb = '{16'h7FFF, 16'h0006, 16'h0002, 16'hFFFE, 16'h0000, 16'h0001, 16'hFFFF};
    er = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'h1234, 16'h0000, 16'h0000};
    ez = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    eo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef DIV32_16_OVF_EN
    eq = '{16'h7FFF, 16'h8000, 16'hFFFD, 16'hFFFD, 16'hFFFF, 16'h7FFF, 16'h7FFF};
`else
    eq = '{16'h7FFF, 16'h8000, 16'hFFFD, 16'hFFFD, 16'hFFFF, 16'h0000, 16'h0000};
`endif
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], q, r, z, o, lat);
      model(va[i], vb[i], mq, mr, mz, mo);
      total++;
      if ({q, r, z} !== {eq[i], er[i], ez[i]}) begin
        bad++;
        $display("FAIL directed[%0d] got q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                 i, q, r, z, eq[i], er[i], ez[i]);
      end
      total++;
      if ({q, r, z} !== {mq, mr, mz}) begin
        bad++;
        $display("FAIL directed_model[%0d] got q=%h r=%h dbz=%b model q=%h r=%h dbz=%b",
                 i, q, r, z, mq, mr, mz);
      end
      total++;
      if (lat != 33) begin bad++; $display("FAIL latency[%0d] got=%0d required=33", i, lat); end
`ifdef DIV32_16_OVF_EN
      total++;
      if (o !== eo[i]) begin bad++; $display("FAIL ovf[%0d] got=%b required=%b", i, o, eo[i]); end
`endif
    end
  endtask

  task automatic test_backpressure();
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    dividend = 32'hFFFFFFF9; divisor = 16'h0002; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i % 2);
      dividend = $urandom; divisor = 16'($urandom);
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, quotient, remainder, dbz} !== {1'b1, 1'b0, 16'hFFFD, 16'hFFFF, 1'b0}) begin
        bad++;
        $display("FAIL backpressure[%0d] out_valid=%b in_ready=%b q=%h r=%h dbz=%b required 1 0 fffd ffff 0",
                 i, out_valid, in_ready, quotient, remainder, dbz);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    repeat (40) @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_ghost out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] q, r;
    logic        z, o;
    int          lat;
    dividend = 32'h12345678; divisor = 16'h0123; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, quotient, remainder, dbz} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset in_ready=%b out_valid=%b q=%h r=%h dbz=%b required 1 0 0000 0000 0",
               in_ready, out_valid, quotient, remainder, dbz);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h3FFF0001, 16'h7FFF, q, r, z, o, lat);
    total++;
    if ({q, r, z} !== {16'h7FFF, 16'h0000, 1'b0} || lat != 33) begin
      bad++;
      $display("FAIL after_reset got q=%h r=%h dbz=%b lat=%0d required 7fff 0000 0 33", q, r, z, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, q, r, mq, mr;
    logic [31:0] p;
    logic        z, o, mz, mo;
    int          lat;
    // Products from the multiplier divide back to the other operand
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (b == 16'h0) b = 16'h0001;
      p = 32'($signed(a) * $signed(b));
      run_op(p, b, q, r, z, o, lat);
      total++;
      if ({q, r, z, o} !== {a, 16'h0000, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL rand_prod[%0d] %h/%h got q=%h r=%h dbz=%b ovf=%b required q=%h r=0000 dbz=0 ovf=0",
                 i, p, b, q, r, z, o, a);
      end
    end
    // Arbitrary operands, including overflow and divide-by-zero cases
    for (int i = 0; i < 200; i++) begin
      p = $urandom;
      b = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom);
      run_op(p, b, q, r, z, o, lat);
      model(p, b, mq, mr, mz, mo);
`ifndef DIV32_16_OVF_EN
      mo = 1'b0;
`endif
      total++;
      if ({q, r, z, o} !== {mq, mr, mz, mo}) begin
        bad++;
        $display("FAIL rand_any[%0d] %h/%h got q=%h r=%h dbz=%b ovf=%b model q=%h r=%h dbz=%b ovf=%b",
                 i, p, b, q, r, z, o, mq, mr, mz, mo);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
